cram_readout_sequencer: RTL and testbench
=========================================

// Module: cram_readout_sequencer
// PURPOSE
//  Streams a contiguous run of words out of one compute-RAM (CRAM) read port into the cram-to-dram swizzle stage.
//  Issues CRAM reads with fixed 1-cycle latency and buffers returned words in a 4-entry skid FIFO.
//  Presents beats as out_valid/out_data/out_last. While out_stall is high, out_valid stays low (swizzle discards beats then).
//  Sits between the CRAM array read port and the swizzle data_valid/ram_data_in/ram_data_last inputs.
// PARAMETERS
//  DWIDTH      40   CRAM port / output data width
//  AWIDTH      9    CRAM address width; addresses wrap mod 2**AWIDTH
//  FIFO_DEPTH  4    skid FIFO entries; fixed, power of two
// PORTS
//  clk          in   1          clock
//  resetn       in   1          synchronous, active-low reset
//  start        in   1          1-cycle pulse; begin a run (ignored when busy=1)
//  start_addr   in   AWIDTH     first CRAM address, sampled on start
//  num_words    in   AWIDTH+1   words in run, 0..512, sampled on start
//  ram_addr     out  AWIDTH     CRAM read address
//  ram_re       out  1          CRAM read enable; ram_rdata valid the following cycle
//  ram_rdata    in   DWIDTH     CRAM read data
//  out_data     out  DWIDTH     beat data (= FIFO head)
//  out_valid    out  1          beat valid, consumed the same cycle (no back-pressure beyond out_stall)
//  out_last     out  1          high with the final beat of the run
//  out_stall    in   1          downstream hold-off (swizzle ready)
//  busy         out  1          run in progress
//  done         out  1          1-cycle pulse, cycle after the final beat
// BEHAVIOUR
//  Reset: ram_re=0, ram_addr=0, out_valid=0, out_last=0, busy=0, done=0; FIFO emptied, in-flight read dropped.
//  FSM IDLE -> READ -> DRAIN -> IDLE.
//   IDLE: on start & num_words!=0 -> load addr/remaining, busy=1, READ. On start & num_words==0 -> done pulse next cycle, stay IDLE.
//   READ: issue ram_re when remaining>0 and (occupancy + inflight) <= 2. On issue ram_addr <= ram_addr+1 (wrap), remaining--.
//         Enter DRAIN when the last read is issued.
//   DRAIN: no reads; leave to IDLE when FIFO empty, no inflight, final beat popped. busy=0, done=1 that cycle.
//  inflight = registered ram_re; when set, ram_rdata pushed into FIFO at the clock edge.
//  Pop: out_valid = ~empty & ~out_stall (combinational); pop on out_valid.
//  out_last = out_valid & (beats_sent == num_words-1); beats_sent counter AWIDTH+1 bits.
//  Throughput: 1 beat/cycle sustained with out_stall low. Latency: start at T -> ram_re T+1 -> first out_valid T+3.
//  FIFO never overflows: issue rule bounds occupancy <= 3 after any stall length. Simultaneous push+pop keeps occupancy.
//  out_stall rising mid-run: beats freeze, reads stop within 1 cycle, data held; resumes in order with no loss or duplication.
//  start while busy: ignored, no state change. Reset mid-run: immediate return to reset state, next start runs cleanly.
//  num_words=512 with start_addr!=0: addresses wrap through 0.
// STRUCTURE
//  Shared package: CRAM_DWIDTH=40, CRAM_AWIDTH=9, CRAM_NUM_WORDS=512, FSM state enum {S_IDLE,S_READ,S_DRAIN}.
//  One sub-module: cram_rd_skid_fifo (DWIDTH x 4, push/pop/count/empty, synchronous reset). Sequencer holds FSM, counters, issue logic.
// TESTING
//  Model CRAM as rdata = {addr pattern}, 1-cycle latency; scoreboard checks order, count, out_last, no drops.
//  1) start_addr=0,num_words=40,no stall -> 40 consecutive beats data 0..39, out_last on beat 39, done 1 cycle later, first beat at T+3.
//  2) num_words=80, out_stall high for 2 cycles after beat 39 -> no out_valid during stall, beats 40..79 resume, none lost/duplicated.
//  3) start_addr=500,num_words=20 -> addresses 500..511 then 0..7, out_last on 20th beat.
//  4) num_words=0 -> no ram_re, no out_valid, done pulse the cycle after start.
//  5) random out_stall 30% over num_words=512 -> 512 ordered beats, FIFO occupancy never >3, exactly one out_last.
//  6) resetn low at beat 10 of 40, then new start num_words=5 -> outputs zero during reset, then exactly 5 clean beats.

Source files
------------

// File: rtl/cram_readout_sequencer_pkg.sv
// Shared CRAM readout constants and sequencer state encoding.
package cram_readout_sequencer_pkg;

    localparam int CRAM_DWIDTH     = 40;
    localparam int CRAM_NUM_WORDS  = 512;
    localparam int CRAM_AWIDTH     = $clog2(CRAM_NUM_WORDS);
    localparam int CRAM_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } seq_state_t;

endpackage

// File: rtl/cram_readout_sequencer_if.sv
// Run command, CRAM read port and beat stream of the readout sequencer.
// master = sequencer side, slave = CRAM array plus swizzle stage.
interface cram_readout_sequencer_if
    import cram_readout_sequencer_pkg::*;
#(
    parameter int DWIDTH = CRAM_DWIDTH,
    parameter int AWIDTH = CRAM_AWIDTH
) ();

    logic              start;
    logic [AWIDTH-1:0] start_addr;
    logic [AWIDTH:0]   num_words;
    logic              busy;
    logic              done;

    logic [AWIDTH-1:0] ram_addr;
    logic              ram_re;
    logic [DWIDTH-1:0] ram_rdata;

    logic [DWIDTH-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_stall;

    modport master (
        input  start, start_addr, num_words, ram_rdata, out_stall,
        output busy, done, ram_addr, ram_re, out_data, out_valid, out_last
    );

    modport slave (
        output start, start_addr, num_words, ram_rdata, out_stall,
        input  busy, done, ram_addr, ram_re, out_data, out_valid, out_last
    );

endinterface

// File: rtl/cram_readout_sequencer_skid_fifo.sv
// Small power-of-two FIFO holding returned CRAM words; head is combinational.
// Latency: push visible at head next cycle; push when full / pop when empty are ignored.
module cram_rd_skid_fifo #(
    parameter int DWIDTH = 40,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic [DWIDTH-1:0]      push_data,
    input  logic                   pop,
    output logic [DWIDTH-1:0]      head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW:0]   CNT_ONE  = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0]   CNT_FULL = {1'b1, {PW{1'b0}}};

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (count != CNT_FULL);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cram_readout_sequencer.sv
// Streams a contiguous CRAM run into the swizzle stage; first beat 3 cycles after start.
// out_stall freezes beats combinationally; reads throttle so the 4-deep skid FIFO never overflows.
module cram_readout_sequencer
    import cram_readout_sequencer_pkg::*;
#(
    parameter int DWIDTH     = CRAM_DWIDTH,
    parameter int AWIDTH     = CRAM_AWIDTH,
    parameter int FIFO_DEPTH = CRAM_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     resetn,
    cram_readout_sequencer_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [AWIDTH-1:0] ADDR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [AWIDTH:0]   WORD_ONE = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [CW:0]       PEND_MAX = {{(CW-1){1'b0}}, 2'b10};

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH:0]   remaining;
    logic [AWIDTH:0]   num_words_q;
    logic [AWIDTH:0]   beats_sent;
    logic              inflight;
    logic              done_q;

    logic              issue;
    logic              load;
    logic              done_nxt;
    logic              pop;
    logic              last_beat;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic [DWIDTH-1:0] fifo_head;
    logic [CW:0]       pending;

    cram_rd_skid_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (inflight),
        .push_data (bus.ram_rdata),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // Words already buffered plus the read whose data lands this cycle.
    assign pending   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign pop       = ~fifo_empty & ~bus.out_stall;
    assign last_beat = pop & (beats_sent == num_words_q - WORD_ONE);

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        load      = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.num_words != '0) begin
                        load      = 1'b1;
                        state_nxt = S_READ;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            S_READ: begin
                // Issuing only at <=2 pending caps the FIFO at 3 after any stall.
                if (remaining != '0 && pending <= PEND_MAX) begin
                    issue = 1'b1;
                    if (remaining == WORD_ONE) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (last_beat) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            remaining   <= '0;
            num_words_q <= '0;
            beats_sent  <= '0;
            inflight    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            done_q   <= done_nxt;
            if (load) begin
                addr_q      <= bus.start_addr;
                remaining   <= bus.num_words;
                num_words_q <= bus.num_words;
                beats_sent  <= '0;
            end else begin
                if (issue) begin
                    addr_q    <= addr_q + ADDR_ONE;
                    remaining <= remaining - WORD_ONE;
                end
                if (pop) begin
                    beats_sent <= beats_sent + WORD_ONE;
                end
            end
        end
    end

    assign bus.ram_addr  = addr_q;
    assign bus.ram_re    = issue;
    assign bus.out_data  = fifo_head;
    assign bus.out_valid = pop;
    assign bus.out_last  = last_beat;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_cram_readout_sequencer.sv
// Scoreboard bench: stimulus queues expected reads/beats, a negedge monitor checks them.
module tb_cram_readout_sequencer;
    import cram_readout_sequencer_pkg::*;

    localparam int DW = CRAM_DWIDTH;
    localparam int AW = CRAM_AWIDTH;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          first;
    } beat_t;

    typedef struct {
        int   addr;
        logic first;
    } rd_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    cram_readout_sequencer_if bus ();

    cram_readout_sequencer dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    beat_t exp_q[$];
    rd_t   rd_q[$];
    int    beat_total   = 0;
    int    outstanding  = 0;
    logic  done_due     = 1'b0;
    int    start_cyc    = 0;
    int    first_re_cyc = -1;
    int    first_bt_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] word_of(input int a);
        logic [AW-1:0] x;
        x = a[AW-1:0];
        return {x, ~x, x, ~x, 4'hA};
    endfunction

    // CRAM model: one-cycle read latency, garbage when not reading.
    always @(posedge clk) begin
        if (bus.ram_re) bus.ram_rdata <= word_of(int'(bus.ram_addr));
        else            bus.ram_rdata <= DW'({$urandom(), $urandom()});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    always @(negedge clk) begin
        logic next_due;
        if (!resetn) begin
            outstanding = 0;
            done_due    = 1'b0;
        end else begin
            next_due = 1'b0;
            if (done_due || bus.done) begin
                check("done_pulse", bus.done, done_due);
                if (bus.done) check("busy_low_at_done", bus.busy, 0);
            end
            if (bus.start && bus.num_words == '0) next_due = 1'b1;
            if (bus.ram_re) begin
                check("pending_le3", outstanding <= 3, 1);
                if (rd_q.size() == 0) flag("extra_ram_re");
                else begin
                    rd_t r;
                    r = rd_q.pop_front();
                    check("ram_addr", bus.ram_addr, r.addr);
                    if (r.first) first_re_cyc = cyc;
                end
            end
            if (bus.out_last && !bus.out_valid) flag("last_without_valid");
            if (bus.out_valid) begin
                check("valid_under_stall", bus.out_stall, 0);
                if (exp_q.size() == 0) flag("extra_beat");
                else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check("beat_data", bus.out_data, b.data);
                    check("beat_last", bus.out_last, b.last);
                    if (b.first) first_bt_cyc = cyc;
                    if (b.last) next_due = 1'b1;
                end
                beat_total++;
            end
            outstanding = outstanding + (bus.ram_re ? 1 : 0) - (bus.out_valid ? 1 : 0);
            done_due = next_due;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input int sa, input int nw, input bit accepted);
        bus.start      = 1'b1;
        bus.start_addr = AW'(sa);
        bus.num_words  = (AW+1)'(nw);
        if (accepted) begin
            for (int i = 0; i < nw; i++) begin
                exp_q.push_back('{word_of(sa + i), (i == nw - 1), (i == 0)});
                rd_q.push_back('{(sa + i) % CRAM_NUM_WORDS, (i == 0)});
            end
            start_cyc = cyc;
        end
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_beats(input int base, input int n, input int limit);
        for (int k = 0; k < limit; k++) begin
            if (beat_total - base >= n) return;
            step();
        end
        flag("timeout_waiting_beats");
    endtask

    task automatic run_to_done(input string name, input int stall_pct, input int limit);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < limit && !seen; k++) begin
            bus.out_stall = ($urandom_range(99) < stall_pct);
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            step();
        end
        bus.out_stall = 1'b0;
        if (!seen) flag({name, "_timeout"});
        check({name, "_beats_left"}, exp_q.size(), 0);
        check({name, "_reads_left"}, rd_q.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_ram_re"}, bus.ram_re, 0);
        check({tag, "_ram_addr"}, bus.ram_addr, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_last"}, bus.out_last, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
    endtask

    initial begin
        int base;
        resetn         = 1'b0;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.num_words  = '0;
        bus.out_stall  = 1'b0;
        repeat (2) step();
        check_reset_state("reset");
        step();
        resetn = 1'b1;
        step();

        // 1: 40 words from 0, latency check, start while busy ignored
        drive_start(0, 40, 1'b1);
        check("busy_after_start", bus.busy, 1);
        repeat (8) step();
        drive_start(100, 7, 1'b0);
        run_to_done("t1", 0, 200);
        check("t1_first_re_latency", first_re_cyc - start_cyc, 1);
        check("t1_first_beat_latency", first_bt_cyc - start_cyc, 3);

        // 2: 80 words, 2-cycle stall after beat 39
        base = beat_total;
        drive_start(0, 80, 1'b1);
        wait_beats(base, 40, 200);
        bus.out_stall = 1'b1;
        repeat (2) step();
        bus.out_stall = 1'b0;
        run_to_done("t2", 0, 300);

        // 3: wrap through address 0
        drive_start(500, 20, 1'b1);
        run_to_done("t3", 0, 200);

        // 4: empty run
        drive_start(0, 0, 1'b0);
        repeat (4) step();
        check("t4_no_reads", rd_q.size(), 0);
        check("t4_busy", bus.busy, 0);

        // 5: full-array run with 30% random stall
        drive_start($urandom_range(CRAM_NUM_WORDS - 1), CRAM_NUM_WORDS, 1'b1);
        run_to_done("t5", 30, 6000);

        // 6: reset at beat 10 of 40, then a clean 5-word run
        base = beat_total;
        drive_start(0, 40, 1'b1);
        wait_beats(base, 10, 200);
        resetn = 1'b0;
        step();
        check_reset_state("midrun_reset");
        step();
        exp_q.delete();
        rd_q.delete();
        resetn = 1'b1;
        step();
        drive_start(300, 5, 1'b1);
        run_to_done("t6", 0, 100);

        // random runs with random stall
        for (int r = 0; r < 4; r++) begin
            drive_start($urandom_range(CRAM_NUM_WORDS - 1), $urandom_range(64, 1), 1'b1);
            run_to_done("rand", 30, 1000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
